// File: rtl/fdct_mult_pkg.sv
// rtl/fdct_mult_pkg.sv - shared defaults and types for the FDCT shared multiplier
package fdct_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NREQ  = 4;

  typedef logic signed [2*DEFAULT_WIDTH-1:0] product_t;

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_mult.sv
// rtl/param_mult.sv - full-precision signed WIDTH x WIDTH multiplier
module param_mult
  import fdct_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [WIDTH-1:0]   a_i,
  input  logic signed [WIDTH-1:0]   b_i,
  output logic signed [2*WIDTH-1:0] y_o
);

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;

  // Sign-extend first so the product is computed at full 2*WIDTH precision.
  assign a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_ext = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign y_o   = a_ext * b_ext;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant starting the scan at ptr_i
module rr_arbiter
  import fdct_mult_pkg::*;
#(
  parameter  int NREQ = DEFAULT_NREQ,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int             cand;
    logic [IDW-1:0] cidx;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    cidx  = '0;
    // Scan from the farthest offset down so the nearest one to ptr_i wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % NREQ;
      cidx = IDW'(cand);
      if (en_i && req_i[cidx]) begin
        idx_o = cidx;
        any_o = 1'b1;
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - one signed multiplier time-shared by NREQ requesters
module mult_share_arb
  import fdct_mult_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int NREQ  = DEFAULT_NREQ,
  localparam int IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*WIDTH-1:0]    res_y,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  logic                    s1_valid_q, s1_valid_d;
  logic signed [WIDTH-1:0] s1_a_q, s1_a_d;
  logic signed [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [IDW-1:0]          s1_id_q, s1_id_d;
  logic                    res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0]      res_y_q, res_y_d;
  logic [IDW-1:0]          res_id_q, res_id_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;

  logic                      adv1, adv2;
  logic [NREQ-1:0]           gnt;
  logic [IDW-1:0]            gidx;
  logic                      gany;
  logic signed [2*WIDTH-1:0] prod;

  assign adv2 = !res_valid_q || res_ready;
  assign adv1 = !s1_valid_q || adv2;

  // Gating with reset_n keeps req_ready low for the whole reset window.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (adv1 && reset_n),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  param_mult #(.WIDTH(WIDTH)) u_mult (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .y_o (prod)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    rr_ptr_d    = rr_ptr_q;
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    res_id_d    = res_id_q;

    if (gany) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a[int'(gidx)*WIDTH +: WIDTH];
      s1_b_d     = req_b[int'(gidx)*WIDTH +: WIDTH];
      s1_id_d    = gidx;
      rr_ptr_d   = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end else if (adv1) begin
      s1_valid_d = 1'b0;
    end

    // Result register only moves when its content is consumed or empty.
    if (adv2) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_y_d  = prod;
        res_id_d = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rr_ptr_q    <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_id_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rr_ptr_q    <= rr_ptr_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_id_q    <= res_id_d;
    end
  end

  assign req_ready = gnt;
  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
  assign res_id    = res_id_q;
  assign busy      = s1_valid_q || res_valid_q;

endmodule
